// File: rtl/data_mem_resp_pkg.sv
// Shared constants and types for the multi-cycle data-memory responder.
package data_mem_resp_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

  // Request payload captured at the accept edge.
  typedef struct packed {
    logic              write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write, combinational read, synchronous clear.
module mem_word_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles, performs the
// access and holds the response until the CPU consumes it.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mem_req_t         lat_req, req_nxt;
  logic [31:0]      rdata_nxt;
  logic             err_nxt;

  logic              err_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] idx_c;
  logic [31:0]       rd_data_c;

  assign idx_c = lat_req.addr[ADDR_W+1:2];
  assign err_c = (lat_req.addr[1:0] != 2'b00) || (lat_req.addr[31:ADDR_W+2] != '0);

  mem_word_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we_c),
    .waddr(idx_c),
    .wdata(lat_req.wdata),
    .raddr(idx_c),
    .rdata(rd_data_c)
  );

  // State and registered outputs; handshake flags decode the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_req    <= '0;
      resp_rdata <= ERR_RDATA;
      resp_err   <= 1'b0;
      resp_valid <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lat_req    <= req_nxt;
      resp_rdata <= rdata_nxt;
      resp_err   <= err_nxt;
      resp_valid <= (state_nxt == ST_RESP);
      req_ready  <= (state_nxt == ST_IDLE);
    end
  end

  // Next-state, latency countdown and access on the final BUSY cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = lat_req;
    rdata_nxt = resp_rdata;
    err_nxt   = resp_err;
    mem_we_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_nxt.write = req_write;
          req_nxt.addr  = req_addr;
          req_nxt.wdata = req_wdata;
          cnt_nxt       = CNT_W'(LATENCY - 1);
          state_nxt     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = ST_RESP;
          err_nxt   = err_c;
          mem_we_c  = lat_req.write && !err_c;
          rdata_nxt = (err_c || lat_req.write) ? ERR_RDATA : rd_data_c;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY=4 and LATENCY=1.
module tb_data_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        l1_req_valid, l1_req_ready, l1_req_write;
  logic [31:0] l1_req_addr, l1_req_wdata;
  logic        l1_resp_valid, l1_resp_ready, l1_resp_err;
  logic [31:0] l1_resp_rdata;

  exp_t        sb4[$];
  exp_t        sb1[$];
  logic [31:0] model4 [1024];
  logic [31:0] model1 [1024];
  int          total = 0;
  int          bad = 0;

  data_mem_responder #(.ADDR_W(10), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
    .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
  );

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      model4[i] = 32'h0;
      model1[i] = 32'h0;
    end
  endtask

  function automatic exp_t predict4(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic [9:0] ix;
    ix      = a[11:2];
    e.err   = addr_err(a);
    e.rdata = (e.err || wr) ? 32'h0 : model4[ix];
    if (!e.err && wr) model4[ix] = d;
    return e;
  endfunction

  function automatic exp_t predict1(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic [9:0] ix;
    ix      = a[11:2];
    e.err   = addr_err(a);
    e.rdata = (e.err || wr) ? 32'h0 : model1[ix];
    if (!e.err && wr) model1[ix] = d;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0; l1_req_wdata = '0;
    l1_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++;
    if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    total++;
    if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", resp_err); end
    total++;
    if (l1_req_ready !== 1'b1) begin bad++; $display("FAIL rst_l1_req_ready got=%b exp=1", l1_req_ready); end
  endtask

  // One transaction on the LATENCY=4 instance; hold = cycles of resp_ready=0 after resp_valid.
  task automatic do_txn(input string name, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    int   w;
    int   cycles;
    exp_t e;
    logic [31:0] rd0;
    logic        er0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    resp_ready = (hold == 0);
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    total++;
    if (!req_ready) begin
      bad++; $display("FAIL %s_accept_timeout got=%b exp=1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    sb4.push_back(predict4(wr, a, d));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL %s_busy_ready got=%b exp=0", name, req_ready); end
    cycles = 0;
    while (!resp_valid && cycles < 40) begin @(negedge clk); cycles++; end
    total++;
    if (cycles !== 4) begin bad++; $display("FAIL %s_latency got=%0d exp=4", name, cycles); end
    e = sb4.pop_front();
    total++;
    if (resp_rdata !== e.rdata) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", name, resp_rdata, e.rdata); end
    total++;
    if (resp_err !== e.err) begin bad++; $display("FAIL %s_err got=%b exp=%b", name, resp_err, e.err); end
    rd0 = resp_rdata;
    er0 = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== er0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_hold%0d got v=%b d=%h e=%b rr=%b exp v=1 d=%h e=%b rr=0",
                 name, i, resp_valid, resp_rdata, resp_err, req_ready, rd0, er0);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_consume got v=%b rr=%b exp v=0 rr=1", name, resp_valid, req_ready);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_basic_load();
    do_txn("load0", 1'b0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_store_load();
    do_txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_txn("ld10", 1'b0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_backpressure();
    do_txn("bp", 1'b0, 32'h10, 32'h0, 6);
  endtask

  task automatic test_errors();
    do_txn("mis_st", 1'b1, 32'h13, 32'hCAFEF00D, 0);
    do_txn("oor_ld", 1'b0, 32'h1000, 32'h0, 0);
    do_txn("ld10b", 1'b0, 32'h10, 32'h0, 2);
  endtask

  task automatic test_reset_mid_busy();
    int stale;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    resp_ready = 1'b1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b exp=1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_state got rr=%b v=%b d=%h e=%b exp rr=1 v=0 d=0 e=0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL mid_stale_resp got=%0d exp=0", stale); end
    resp_ready = 1'b0;
    do_txn("ld20", 1'b0, 32'h20, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic        wr [6];
    logic [31:0] ad [6];
    logic [31:0] dt [6];
    int   k;
    int   prev_acc;
    exp_t e;
    wr[0] = 1'b1; ad[0] = 32'h4;   dt[0] = 32'hA5A5_0001;
    wr[1] = 1'b1; ad[1] = 32'h8;   dt[1] = 32'h5A5A_0002;
    wr[2] = 1'b0; ad[2] = 32'h4;   dt[2] = 32'h0;
    wr[3] = 1'b0; ad[3] = 32'h8;   dt[3] = 32'h0;
    wr[4] = 1'b0; ad[4] = 32'hC;   dt[4] = 32'h0;
    wr[5] = 1'b0; ad[5] = 32'hFFE; dt[5] = 32'h0;
    k = 0;
    prev_acc = -100;
    l1_resp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (k < 6 || sb1.size() > 0); cyc++) begin
      @(negedge clk);
      if (l1_resp_valid) begin
        total++;
        if (sb1.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_resp got=1 exp=0");
        end else begin
          e = sb1.pop_front();
          if (l1_resp_rdata !== e.rdata || l1_resp_err !== e.err || cyc != prev_acc + 2) begin
            bad++;
            $display("FAIL b2b_resp got d=%h e=%b at=%0d exp d=%h e=%b at=%0d",
                     l1_resp_rdata, l1_resp_err, cyc, e.rdata, e.err, prev_acc + 2);
          end
        end
      end
      if (l1_req_ready && k < 6) begin
        if (k > 0) begin
          total++;
          if (cyc - prev_acc != 3) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - prev_acc);
          end
        end
        l1_req_valid = 1'b1; l1_req_write = wr[k]; l1_req_addr = ad[k]; l1_req_wdata = dt[k];
        sb1.push_back(predict1(wr[k], ad[k], dt[k]));
        prev_acc = cyc;
        k++;
      end else begin
        l1_req_valid = 1'b0;
      end
    end
    l1_req_valid = 1'b0;
    total++;
    if (k != 6 || sb1.size() != 0) begin
      bad++; $display("FAIL b2b_drain got issued=%0d pending=%0d exp issued=6 pending=0", k, sb1.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_store_load();
    test_backpressure();
    test_errors();
    test_reset_mid_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that serves the CPU's load/store requests over a valid/ready request–response handshake. It replaces the zero-latency combinational data memory. The CPU datapath acts as initiator and stalls until a response returns. The block holds a word-addressed array, accepts one request at a time, waits a programmable number of cycles, performs the access, and holds the response until the CPU takes it.

## Interface
Parameters:
- ADDR_W, 10 — word-index width; array depth is 2^ADDR_W 32-bit words.
- LATENCY, 4 — cycles from request accept to response valid; legal range 1..15.

Ports:
- Clock and reset: one clock (`clk`); `reset` is synchronous and active-high.
- clk  in  1  — rising-edge clock.
- reset  in  1  — synchronous, active-high.
- req_valid  in  1  — CPU presents a request.
- req_ready  out  1  — responder can accept a request (IDLE only).
- req_write  in  1  — 1 = store, 0 = load.
- req_addr  in  32  — byte address.
- req_wdata  in  32  — store data.
- resp_valid  out  1  — response available.
- resp_ready  in  1  — CPU consumes the response.
- resp_rdata  out  32  — load data; 0 for stores and errors.
- resp_err  out  1  — misaligned or out-of-range access.

## Operation
- FSM with three states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture write, addr, wdata; load cnt=LATENCY-1; go to BUSY.
  - BUSY: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access, register rdata/err, and go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE. Otherwise hold.
- Word index = addr[ADDR_W+1:2].
- err = (addr[1:0]!=0) || (addr[31:ADDR_W+2]!=0).
- On error: no array write, rdata=0, err=1.
- Load: rdata = mem[index]. Store: mem[index] <= wdata at the access edge; rdata=0.
- Request fields are sampled only at the accept edge; later changes on req_* are ignored.
- resp_rdata and resp_err are stable for the whole time resp_valid is high.
- Reset (any state, including mid-BUSY or RESP):
  - state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after the reset edge.
  - All array words are zeroed.
  - A pending store whose access edge has not occurred is dropped.
- A store followed by a load to the same word returns the stored value; there are no ordering hazards because only one request is outstanding.

## Timing
- Accept edge = E0. resp_valid is visible after edge E0+LATENCY.
- A response consumed at edge E1 returns the FSM to IDLE; the next accept is possible at the earliest at E1+1.
- Minimum request-to-request spacing = LATENCY+2 cycles.
- resp_valid does not depend combinationally on resp_ready.
- req_ready is a registered state decode and does not depend combinationally on req_valid.
- The store becomes visible to a load accepted at any edge after the access edge.

## Structure
- Shared package `data_mem_resp_pkg` contains:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - CNT_W=4;
  - constant for the error rdata (32'h0).
- Sub-module `mem_word_array` holds the 2^ADDR_W×32 storage with a synchronous write port, a combinational read port, and synchronous clear on reset.
- The FSM, counter, and error check live in data_mem_responder.

## Test plan
- Reset then idle, LATENCY=4:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - A load from 0x0 returns 0 with resp_valid rising 4 cycles after accept.
- Store 0xDEADBEEF to 0x10, then load 0x10:
  - load returns 0xDEADBEEF, resp_err=0;
  - the store response has rdata=0.
- Backpressure: hold resp_ready=0 for 6 cycles after resp_valid.
  - resp_valid, rdata, and err stay constant;
  - req_ready stays 0;
  - the next request is accepted only after resp_ready=1 plus one cycle.
- Misaligned store to 0x13 and out-of-range load from 0x1000 (ADDR_W=10):
  - both give resp_err=1, rdata=0;
  - the word at 0x10 is unchanged.
- Reset mid-BUSY during a store of 0x12345678 to 0x20, then load 0x20:
  - returns 0, and no stale response appears.
- LATENCY=1 back-to-back loads with resp_ready held 1:
  - resp_valid is high one cycle after each accept;
  - accepts occur every 3 cycles.
